// File: rtl/keypad_cmd_queue.sv
// -----------------------------------------------------------------------------
// keypad_cmd_queue
//
// Takes the key code and key-down level from the 4x4 keypad scanner and turns
// them into maze commands. The module synchronises and debounces the input
// pair and maps keys to commands. It generates press and auto-repeat events
// and buffers them in a 4-entry FIFO. The maze logic drains that FIFO through
// a valid/ready handshake.
//
// Parameters:
//   DEBOUNCE       cycles the synchronised pair must be stable to be accepted
//   REPEAT_DELAY   cycles from a press event to the first auto-repeat
//   REPEAT_PERIOD  cycles between later auto-repeats
//   CNT_W          width of the debounce and repeat counters
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high; clears all state
//   key_down   in   scanner key-pressed level (asynchronous to clk)
//   key_value  in   scanner key code 0-15
//   cmd_valid  out  FIFO non-empty
//   cmd        out  head command: 0 up, 1 down, 2 left, 3 right, 4 restart
//   cmd_ready  in   consumer takes the head on cmd_valid & cmd_ready
//   overflow   out  one-cycle pulse when a command is dropped (FIFO full)
// -----------------------------------------------------------------------------
module keypad_cmd_queue #(
  parameter int DEBOUNCE      = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_down,
  input  logic [3:0] key_value,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [2:0]       CMD_RESTART = 3'd4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_FIRST  = 2'd1,
    HOLD_REPEAT = 2'd2
  } state_t;

  // Key-to-command map: bit 3 flags a mapped key, bits 2:0 carry the command.
  function automatic logic [3:0] map_key(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      4'd2:    res = {1'b1, 3'd0};
      4'd8:    res = {1'b1, 3'd1};
      4'd4:    res = {1'b1, 3'd2};
      4'd6:    res = {1'b1, 3'd3};
      4'd15:   res = {1'b1, 3'd4};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic [4:0]       sync1_r;
  logic [4:0]       sync2_r;
  logic [4:0]       cand_r;
  logic [CNT_W-1:0] db_cnt_r;
  logic             dn_r;
  logic [3:0]       dv_r;
  logic             d_load_s;
  logic             dn_next_s;
  logic [3:0]       dv_next_s;

  // Two-flop synchroniser on the {key_down, key_value} pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'd0;
      sync2_r <= 5'd0;
    end else begin
      sync1_r <= {key_down, key_value};
      sync2_r <= sync1_r;
    end
  end

  // Candidate tracking: restart the stability count whenever the pair moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_r   <= 5'd0;
      db_cnt_r <= CNT_ZERO;
    end else if (sync2_r != cand_r) begin
      cand_r   <= sync2_r;
      db_cnt_r <= CNT_ZERO;
    end else if (db_cnt_r != CNT_MAX) begin
      db_cnt_r <= db_cnt_r + CNT_ONE;
    end
  end

  // The event logic looks at the value D takes at this edge. A fresh press
  // is therefore queued on the same edge that the debounced pair updates.
  assign d_load_s  = (db_cnt_r == DB_LAST);
  assign dn_next_s = d_load_s ? cand_r[4]   : dn_r;
  assign dv_next_s = d_load_s ? cand_r[3:0] : dv_r;

  // Debounced pair D = {dn, dv}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dn_r <= 1'b0;
      dv_r <= 4'd0;
    end else if (d_load_s) begin
      dn_r <= cand_r[4];
      dv_r <= cand_r[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Press / auto-repeat FSM
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] rep_cnt_r;
  logic             rise_s;
  logic             fall_s;
  logic             roll_s;
  logic             press_s;
  logic             repeat_s;
  logic             cnt_clr_s;

  assign rise_s = ~dn_r & dn_next_s;
  assign fall_s = dn_r & ~dn_next_s;
  // Rollover: still held, but the scanner now reports a different key.
  assign roll_s = dn_r & dn_next_s & (dv_next_s != dv_r);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a release outranks rollover, which outranks the timer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_next_s = HOLD_FIRST;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD_FIRST: begin
        if (fall_s) begin
          state_next_s = IDLE;
        end else if (roll_s) begin
          state_next_s = HOLD_FIRST;
        end else if (rep_cnt_r == DELAY_LAST) begin
          state_next_s = HOLD_REPEAT;
        end else begin
          state_next_s = HOLD_FIRST;
        end
      end
      HOLD_REPEAT: begin
        if (fall_s) begin
          state_next_s = IDLE;
        end else if (roll_s) begin
          state_next_s = HOLD_FIRST;
        end else begin
          state_next_s = HOLD_REPEAT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: event strobes and repeat-counter clear.
  always_comb begin
    press_s   = 1'b0;
    repeat_s  = 1'b0;
    cnt_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          press_s   = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          press_s   = 1'b0;
        end
      end
      HOLD_FIRST: begin
        if (fall_s) begin
          cnt_clr_s = 1'b0;
        end else if (roll_s) begin
          press_s   = 1'b1;
          cnt_clr_s = 1'b1;
        end else if (rep_cnt_r == DELAY_LAST) begin
          repeat_s  = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
      HOLD_REPEAT: begin
        if (fall_s) begin
          cnt_clr_s = 1'b0;
        end else if (roll_s) begin
          press_s   = 1'b1;
          cnt_clr_s = 1'b1;
        end else if (rep_cnt_r == PERIOD_LAST) begin
          repeat_s  = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          cnt_clr_s = 1'b0;
        end
      end
      default: begin
        press_s   = 1'b0;
        repeat_s  = 1'b0;
        cnt_clr_s = 1'b0;
      end
    endcase
  end

  // Repeat timer: counts hold cycles since the last event while a key is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_r <= CNT_ZERO;
    end else if (cnt_clr_s) begin
      rep_cnt_r <= CNT_ZERO;
    end else if ((state_r != IDLE) && (rep_cnt_r != CNT_MAX)) begin
      rep_cnt_r <= rep_cnt_r + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Event filter: unmapped keys never queue; restart never auto-repeats.
  // ---------------------------------------------------------------------------
  logic [3:0] key_code_s;
  logic [2:0] push_code_s;
  logic       push_s;

  assign key_code_s  = map_key(dv_next_s);
  assign push_code_s = key_code_s[2:0];
  assign push_s      = key_code_s[3] &
                       (press_s | (repeat_s & (push_code_s != CMD_RESTART)));

  // ---------------------------------------------------------------------------
  // 4-entry command FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [2:0] mem_r [4];
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] count_r;
  logic [2:0] count_next_s;
  logic [2:0] cmd_r;
  logic [2:0] head_next_s;
  logic       cmd_valid_r;
  logic       overflow_r;
  logic       pop_s;
  logic       full_s;
  logic       wr_en_s;
  logic       drop_s;

  assign pop_s   = cmd_ready & (count_r != 3'd0);
  assign full_s  = (count_r == 3'd4);
  // When full, a simultaneous pop frees the slot that the push reuses.
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // Occupancy after this edge.
  always_comb begin
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + 3'd1;
      2'b01:   count_next_s = count_r - 3'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Head after this edge. It is the next stored entry on a pop of a deep
  // queue, or the incoming command when it lands at the front. Otherwise
  // the head is held, which also keeps the last value while empty.
  always_comb begin
    head_next_s = cmd_r;
    if (pop_s && (count_r > 3'd1)) begin
      head_next_s = mem_r[rd_ptr_r + 2'd1];
    end else if (wr_en_s && ((count_r == 3'd0) || (pop_s && (count_r == 3'd1)))) begin
      head_next_s = push_code_s;
    end else begin
      head_next_s = cmd_r;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= 3'd0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r <= count_next_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_r       <= 3'd0;
      cmd_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      cmd_r       <= head_next_s;
      cmd_valid_r <= (count_next_s != 3'd0);
      overflow_r  <= drop_s;
    end
  end

  assign cmd       = cmd_r;
  assign cmd_valid = cmd_valid_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_cmd_queue.sv
module tb_keypad_cmd_queue;

  localparam int DEBOUNCE      = 4;
  localparam int REPEAT_DELAY  = 10;
  localparam int REPEAT_PERIOD = 5;
  localparam int CNT_W         = 8;

  logic       clk;
  logic       reset;
  logic       key_down;
  logic [3:0] key_value;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       overflow;

  int checks;
  int errors;

  keypad_cmd_queue #(
    .DEBOUNCE(DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_down(key_down),
    .key_value(key_value),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .cmd_ready(cmd_ready),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Raw samples reach the debouncer two edges late. A value is accepted once it
  // has been seen for DEBOUNCE consecutive samples. Repeats are due at absolute
  // edge numbers. The FIFO is a queue.
  logic [4:0] raw_q[$];
  logic [4:0] run_val;
  int         run_len;
  logic       m_dn;
  logic [3:0] m_dv;
  int         next_fire;
  int         mt;
  logic [2:0] q[$];
  logic       m_valid;
  logic [2:0] m_head;
  logic       m_ovf;

  function automatic int code_of(input logic [3:0] k);
    case (k)
      4'd2:    return 0;
      4'd8:    return 1;
      4'd4:    return 2;
      4'd6:    return 3;
      4'd15:   return 4;
      default: return -1;
    endcase
  endfunction

  task automatic m_reset();
    raw_q.delete();
    raw_q.push_back(5'd0);
    raw_q.push_back(5'd0);
    run_val   = 5'd0;
    run_len   = 1;
    m_dn      = 1'b0;
    m_dv      = 4'd0;
    next_fire = 0;
    mt        = 0;
    q.delete();
    m_valid   = 1'b0;
    m_head    = 3'd0;
    m_ovf     = 1'b0;
  endtask

  task automatic m_step();
    logic [4:0] p;
    logic [4:0] acc;
    logic       take;
    logic       new_dn;
    logic [3:0] new_dv;
    logic       press;
    logic       rpt;
    logic       push;
    logic       pop;
    logic [2:0] tmp;
    int         code;
    int         pre;
    p = raw_q.pop_front();
    raw_q.push_back({key_down, key_value});
    take = (run_len == DEBOUNCE);
    acc  = run_val;
    if (p == run_val) run_len++;
    else begin
      run_val = p;
      run_len = 1;
    end
    new_dn = take ? acc[4] : m_dn;
    new_dv = take ? acc[3:0] : m_dv;
    press = 1'b0;
    rpt   = 1'b0;
    if (new_dn && (!m_dn || (new_dv != m_dv))) begin
      press = 1'b1;
      next_fire = mt + REPEAT_DELAY;
    end else if (new_dn && m_dn && (mt == next_fire)) begin
      rpt = 1'b1;
      next_fire = mt + REPEAT_PERIOD;
    end
    code = code_of(new_dv);
    push = (code >= 0) && (press || (rpt && code != 4));
    pre  = q.size();
    pop  = cmd_ready && (pre > 0);
    if (pop) tmp = q.pop_front();
    m_ovf = 1'b0;
    if (push) begin
      if (pre == 4 && !pop) m_ovf = 1'b1;
      else q.push_back(3'(code));
    end
    m_dn = new_dn;
    m_dv = new_dv;
    mt++;
    m_valid = (q.size() > 0);
    if (m_valid) m_head = q[0];
  endtask

  // One clock: model advances on the rising edge; outputs are read on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) m_reset();
    else m_step();
    @(negedge clk);
  endtask

  task automatic set_key(input logic dn, input logic [3:0] v);
    key_down  = dn;
    key_value = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    cmd_ready = 1'b0;
    set_key(1'b0, 4'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    checks++;
    if (cmd !== 3'd0) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", cmd_valid); end
  endtask

  task automatic test_debounce();
    int lat;
    int seen;
    do_reset();
    set_key(1'b1, 4'd2);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (cmd_valid) lat = i;
    end
    set_key(1'b0, 4'd2);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL debounce_latency: got %0d edges expected 7", lat); end
    checks++;
    if (cmd !== 3'd0) begin errors++; $display("FAIL debounce_cmd: got %0d expected 0", cmd); end
    for (int i = 0; i < 12; i++) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL debounce_single: got valid %b expected 0", cmd_valid); end
    set_key(1'b1, 4'd2);
    for (int i = 0; i < 3; i++) tick();
    set_key(1'b0, 4'd2);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL glitch_ignored: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_repeat();
    int exp_t[7] = '{0, 10, 15, 20, 25, 30, 35};
    int acc[$];
    int found;
    int bad_cmd;
    do_reset();
    cmd_ready = 1'b1;
    set_key(1'b1, 4'd6);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (cmd_valid) found = 1;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL repeat_press_timeout: got no command expected press"); end
    acc.push_back(0);
    bad_cmd = (cmd !== 3'd3) ? 1 : 0;
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (cmd_valid) begin
        acc.push_back(t);
        if (cmd !== 3'd3) bad_cmd++;
      end
      if (t == 30) set_key(1'b0, 4'd6);
    end
    checks++;
    if (acc.size() != 7) begin errors++; $display("FAIL repeat_count: got %0d accepts expected 7", acc.size()); end
    checks++;
    if (bad_cmd != 0) begin errors++; $display("FAIL repeat_cmd: got %0d wrong codes expected 0", bad_cmd); end
    for (int i = 0; i < 7 && i < acc.size(); i++) begin
      checks++;
      if (acc[i] != exp_t[i]) begin errors++; $display("FAIL repeat_time[%0d]: got %0d expected %0d", i, acc[i], exp_t[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] keys[5] = '{4'd2, 4'd8, 4'd4, 4'd6, 4'd15};
    int ovf_n;
    int ovf_key;
    int got[$];
    do_reset();
    ovf_n = 0;
    ovf_key = -1;
    for (int k = 0; k < 5; k++) begin
      set_key(1'b1, keys[k]);
      for (int i = 0; i < 18; i++) begin
        if (i == 8) set_key(1'b0, keys[k]);
        tick();
        if (overflow) begin ovf_n++; ovf_key = k; end
      end
    end
    checks++;
    if (ovf_n != 1) begin errors++; $display("FAIL overflow_pulses: got %0d expected 1", ovf_n); end
    checks++;
    if (ovf_key != 4) begin errors++; $display("FAIL overflow_key: got %0d expected 4", ovf_key); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid) got.push_back(int'(cmd));
      tick();
    end
    cmd_ready = 1'b0;
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL overflow_drain_len: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] != i) begin errors++; $display("FAIL overflow_order[%0d]: got %0d expected %0d", i, got[i], i); end
    end
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL overflow_empty: got %b expected 0", cmd_valid); end
  endtask

  task automatic test_full_pop_push();
    logic [3:0] keys[4] = '{4'd2, 4'd8, 4'd4, 4'd6};
    int ovf_n;
    int got[$];
    do_reset();
    ovf_n = 0;
    for (int k = 0; k < 4; k++) begin
      set_key(1'b1, keys[k]);
      for (int i = 0; i < 18; i++) begin
        if (i == 8) set_key(1'b0, keys[k]);
        tick();
        if (overflow) ovf_n++;
      end
    end
    set_key(1'b1, 4'd15);
    for (int i = 0; i < 6; i++) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    set_key(1'b0, 4'd15);
    if (overflow) ovf_n++;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (overflow) ovf_n++;
    end
    checks++;
    if (ovf_n != 0) begin errors++; $display("FAIL fullpp_overflow: got %0d pulses expected 0", ovf_n); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid) got.push_back(int'(cmd));
      tick();
    end
    cmd_ready = 1'b0;
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL fullpp_occupancy: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] != i + 1) begin errors++; $display("FAIL fullpp_order[%0d]: got %0d expected %0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_rollover();
    int exp_t[4] = '{0, 7, 17, 22};
    int exp_c[4] = '{0, 1, 1, 1};
    int at[$];
    int ac[$];
    int found;
    int restarts;
    int others;
    do_reset();
    cmd_ready = 1'b1;
    set_key(1'b1, 4'd2);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (cmd_valid) found = 1;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL rollover_timeout: got no command expected press"); end
    at.push_back(0);
    ac.push_back(int'(cmd));
    set_key(1'b1, 4'd8);
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (cmd_valid) begin at.push_back(t); ac.push_back(int'(cmd)); end
      if (t == 18) set_key(1'b0, 4'd8);
    end
    checks++;
    if (at.size() != 4) begin errors++; $display("FAIL rollover_count: got %0d expected 4", at.size()); end
    for (int i = 0; i < 4 && i < at.size(); i++) begin
      checks++;
      if (at[i] != exp_t[i] || ac[i] != exp_c[i])
        begin errors++; $display("FAIL rollover_evt[%0d]: got t=%0d cmd=%0d expected t=%0d cmd=%0d", i, at[i], ac[i], exp_t[i], exp_c[i]); end
    end
    restarts = 0;
    others = 0;
    set_key(1'b1, 4'd15);
    for (int i = 0; i < 120; i++) begin
      if (i == 100) set_key(1'b0, 4'd15);
      tick();
      if (cmd_valid && cmd == 3'd4) restarts++;
      else if (cmd_valid) others++;
    end
    checks++;
    if (restarts != 1 || others != 0)
      begin errors++; $display("FAIL restart_once: got %0d restart %0d other expected 1 and 0", restarts, others); end
  endtask

  task automatic test_reset_mid();
    int found;
    int lat;
    do_reset();
    set_key(1'b1, 4'd2);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (cmd_valid) found = 1;
    end
    for (int i = 0; i < 17; i++) tick();
    reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", cmd_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b expected 0", overflow); end
    checks++;
    if (cmd !== 3'd0) begin errors++; $display("FAIL midreset_cmd: got %0d expected 0", cmd); end
    tick();
    tick();
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (cmd_valid) lat = i;
    end
    checks++;
    if (lat != 7 || cmd !== 3'd0)
      begin errors++; $display("FAIL midreset_fresh_press: got lat %0d cmd %0d expected 7 and 0", lat, cmd); end
    set_key(1'b0, 4'd2);
  endtask

  task automatic test_unmapped();
    int seen;
    do_reset();
    set_key(1'b1, 4'd5);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cmd_valid || overflow) seen++;
    end
    set_key(1'b0, 4'd5);
    checks++;
    if (seen != 0) begin errors++; $display("FAIL unmapped_key5: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_random();
    logic [3:0] pool[8] = '{4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd5, 4'd0, 4'd2};
    int dur;
    int pct;
    do_reset();
    for (int seg = 0; seg < 50; seg++) begin
      if (seg == 25) begin
        reset = 1'b1;
        m_reset();
        tick();
        reset = 1'b0;
      end
      if ($urandom_range(0, 9) < 7) begin
        set_key(1'b1, pool[$urandom_range(0, 7)]);
        dur = $urandom_range(1, 30);
      end else begin
        set_key(1'b0, pool[$urandom_range(0, 7)]);
        dur = $urandom_range(1, 20);
      end
      pct = $urandom_range(0, 100);
      for (int i = 0; i < dur; i++) begin
        cmd_ready = ($urandom_range(0, 99) < pct);
        tick();
        checks++;
        if (cmd_valid !== m_valid) begin errors++; $display("FAIL rand_valid @%0d: got %b expected %b", mt, cmd_valid, m_valid); end
        checks++;
        if (cmd !== m_head) begin errors++; $display("FAIL rand_cmd @%0d: got %0d expected %0d", mt, cmd, m_head); end
        checks++;
        if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow @%0d: got %b expected %b", mt, overflow, m_ovf); end
      end
    end
    cmd_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    key_down  = 1'b0;
    key_value = 4'd0;
    cmd_ready = 1'b0;
    m_reset();
    test_reset();
    test_debounce();
    test_repeat();
    test_overflow();
    test_full_pop_push();
    test_rollover();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
